// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared types and constants for the sequential divider.
//   XLEN         default operand width
//   DIV_TAG_W    default request/response tag width
//   div_state_t  divider control states
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_TAG_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        RESP  = 2'd3
    } div_state_t;

endpackage

// File: rtl/seq_divider_step.sv
// div_nr_step -- one combinational non-restoring division step.
//   acc       current partial remainder (WIDTH+1 bits, two's complement)
//   q_msb     next dividend bit shifted into the accumulator
//   divisor   divisor magnitude
//   acc_next  partial remainder after the add/subtract
//   q_bit     quotient bit produced by this step
module div_nr_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   acc_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {acc[WIDTH-1:0], q_msb};
        // A negative partial remainder is repaired by adding on the next
        // step instead of restoring it now.
        if (acc[WIDTH]) begin
            acc_next = shifted + {1'b0, divisor};
        end else begin
            acc_next = shifted - {1'b0, divisor};
        end
        q_bit = ~acc_next[WIDTH];
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider -- multi-cycle signed/unsigned integer divider, one
// non-restoring step per clock, with valid/ready request and response.
//   clk, reset_n             clock, asynchronous active-low reset
//   flush                    synchronous abort of the operation in flight
//   req_valid/req_ready      request handshake
//   req_signed, req_rem      signed operation; return remainder
//   req_dividend/divisor     operands
//   req_tag                  opaque tag echoed on the response
//   resp_valid/resp_ready    response handshake
//   resp_data/tag/dbz        result, echoed tag, divide-by-zero flag
//   busy                     high whenever the controller is not IDLE
// Build option: define DIV_EARLY_OUT_EN to skip the iteration for
// divide-by-zero, signed overflow and |dividend| < |divisor|.
module seq_divider
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int TAG_W = DIV_TAG_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_signed,
    input  logic             req_rem,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_dbz,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state, state_next;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic             q_neg, r_neg, rem_sel, dbz, early;
    logic [TAG_W-1:0] tag;

    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             early_hit;
    logic [WIDTH-1:0] load_quo;
    logic [WIDTH:0]   load_acc;

    logic [WIDTH:0]   step_acc;
    logic             step_q;
    logic [WIDTH-1:0] rem_mag, quo_fix, rem_fix;

    assign req_ready  = (state == IDLE) && !flush;
    assign accept     = req_valid && req_ready;
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP);

    assign a_neg = req_signed & req_dividend[WIDTH-1];
    assign b_neg = req_signed & req_divisor[WIDTH-1];
    assign a_mag = a_neg ? -req_dividend : req_dividend;
    assign b_mag = b_neg ? -req_divisor  : req_divisor;

`ifdef DIV_EARLY_OUT_EN
    logic ovf;
    assign ovf = req_signed && (req_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                            && (req_divisor == '1);
    assign early_hit = (b_mag == '0) || ovf || (a_mag < b_mag);
    // Preload the final magnitudes so FIXUP sees the same registers the
    // full iteration would have left behind.
    assign load_quo  = (early_hit && ovf) ? a_mag : (early_hit ? '0 : a_mag);
    assign load_acc  = (early_hit && !ovf) ? {1'b0, a_mag} : '0;
`else
    assign early_hit = 1'b0;
    assign load_quo  = a_mag;
    assign load_acc  = '0;
`endif

    div_nr_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .q_msb    (quo[WIDTH-1]),
        .divisor  (dvs),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    // Final correction: repair a negative remainder, then apply signs.
    // Divide-by-zero leaves |dividend| as remainder, which the sign
    // correction turns back into the original dividend.
    assign rem_mag = acc[WIDTH] ? (acc[WIDTH-1:0] + dvs) : acc[WIDTH-1:0];
    assign quo_fix = dbz ? '1 : (q_neg ? -quo : quo);
    assign rem_fix = r_neg ? -rem_mag : rem_mag;

    always_comb begin
        // NOTE: default first so no path through the case infers a latch.
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (early || cnt == CNT_W'(1)) state_next = FIXUP;
            FIXUP:   state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush && state != IDLE) begin
            state_next = IDLE;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            quo       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            rem_sel   <= 1'b0;
            dbz       <= 1'b0;
            early     <= 1'b0;
            tag       <= '0;
            resp_data <= '0;
            resp_tag  <= '0;
            resp_dbz  <= 1'b0;
        end else begin
            if (accept) begin
                acc     <= load_acc;
                quo     <= load_quo;
                dvs     <= b_mag;
                cnt     <= CNT_W'(WIDTH);
                q_neg   <= a_neg ^ b_neg;
                r_neg   <= a_neg;
                rem_sel <= req_rem;
                dbz     <= (req_divisor == '0);
                early   <= early_hit;
                tag     <= req_tag;
            end else if (state == CALC && !early) begin
                acc <= step_acc;
                quo <= {quo[WIDTH-2:0], step_q};
                cnt <= cnt - CNT_W'(1);
            end
            if (state == FIXUP && !flush) begin
                resp_data <= rem_sel ? rem_fix : quo_fix;
                resp_tag  <= tag;
                resp_dbz  <= dbz;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider -- randomized and directed self-checking bench for
// seq_divider (WIDTH=32) against a plain-arithmetic reference model.
// Honours DIV_EARLY_OUT_EN for the expected latency.
module tb_seq_divider;

    localparam int W = 32;
    localparam int T = 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_signed = 1'b0;
    logic         req_rem = 1'b0;
    logic [W-1:0] req_dividend = '0;
    logic [W-1:0] req_divisor = '0;
    logic [T-1:0] req_tag = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [W-1:0] resp_data;
    logic [T-1:0] resp_tag;
    logic         resp_dbz;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    seq_divider #(.WIDTH(W), .TAG_W(T)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_signed   (req_signed),
        .req_rem      (req_rem),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_tag      (req_tag),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_tag     (resp_tag),
        .resp_dbz     (resp_dbz),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: integer division semantics with the two special cases.
    function automatic logic [W:0] model(input logic s, input logic r,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, m;
        longint sa, sb;
        if (b == 0) begin
            q = '1;
            m = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = W'(sa / sb);
            m = W'(sa % sb);
        end else begin
            q = a / b;
            m = a % b;
        end
        return {(b == 0), (r ? m : q)};
    endfunction

    function automatic int exp_latency(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint la, lb;
        la = s ? longint'($signed(a)) : longint'(a);
        lb = s ? longint'($signed(b)) : longint'(b);
        if (la < 0) la = -la;
        if (lb < 0) lb = -lb;
`ifdef DIV_EARLY_OUT_EN
        if (lb == 0 || la < lb || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
`endif
        return W + 1;
    endfunction

    // Issue one request, wait for the response, hold off resp_ready for
    // 'hold' cycles, then complete the handshake.
    task automatic run_op(input logic s, input logic r, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [T-1:0] t, input int hold);
        logic [W:0] e;
        int lat;
        e = model(s, r, a, b);
        @(negedge clk);
        req_valid = 1'b1; req_signed = s; req_rem = r;
        req_dividend = a; req_divisor = b; req_tag = t; resp_ready = 1'b0;
        check("req_ready_before", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) begin
            check("resp_timeout", 0, 1);
            return;
        end
        check("latency", lat, exp_latency(s, a, b));
        check("data", resp_data, e[W-1:0]);
        check("tag", resp_tag, t);
        check("dbz", resp_dbz, e[W]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", resp_valid, 1);
            check("hold_data", resp_data, e[W-1:0]);
            check("hold_tag", resp_tag, t);
            check("hold_ready", req_ready, 0);
            check("hold_busy", busy, 1);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("post_valid", resp_valid, 0);
        check("post_ready", req_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [W-1:0] a, b;
        logic s, r;

        // Reset state
        #2;
        check("rst_ready", req_ready, 1);
        check("rst_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", resp_data, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel_ready", req_ready, 1);

        // Directed cases
        run_op(0, 0, 100, 7, 5'h13, 0);
        run_op(0, 1, 100, 7, 5'h13, 0);
        run_op(1, 0, -32'sd7, 2, 5'h01, 0);
        run_op(1, 1, -32'sd7, 2, 5'h02, 0);
        run_op(1, 0, 7, -32'sd2, 5'h03, 0);
        run_op(1, 1, 7, -32'sd2, 5'h04, 0);
        run_op(0, 0, 32'h1234, 0, 5'h05, 0);
        run_op(0, 1, 32'h1234, 0, 5'h06, 0);
        run_op(1, 1, 32'h8000_1234, 0, 5'h07, 0);
        run_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'h08, 0);
        run_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'h09, 0);
        run_op(0, 0, 3, 9, 5'h0A, 0);
        run_op(0, 0, 32'hDEAD_BEEF, 32'h0000_0123, 5'h1F, 10);

        // Flush ten cycles into the iteration
        @(negedge clk);
        req_valid = 1'b1; req_signed = 1'b0; req_rem = 1'b0;
        req_dividend = 32'h1234_5678; req_divisor = 3; req_tag = 5'h0B;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        req_valid = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("flush_valid", resp_valid, 0);
        check("flush_busy", busy, 0);
        check("flush_ready_blocked", req_ready, 0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        #1;
        check("flush_ready_after", req_ready, 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        check("flush_no_resp", seen, 0);
        run_op(0, 0, 32'hFFFF_FFFF, 32'h10, 5'h0C, 0);

        // Asynchronous reset in the middle of the iteration
        @(negedge clk);
        req_valid = 1'b1; req_signed = 1'b1; req_rem = 1'b0;
        req_dividend = 32'h7654_3210; req_divisor = 5; req_tag = 5'h0D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", resp_data, 0);
        check("mid_rst_tag", resp_tag, 0);
        check("mid_rst_dbz", resp_dbz, 0);
        check("mid_rst_ready", req_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(1, 0, -32'sd1000, 7, 5'h0E, 0);

        // Randomized operations
        for (int k = 0; k < 60; k++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = $urandom_range(1, 15);
                2: b = -$urandom_range(1, 15);
                3: begin b = $urandom; a = $urandom_range(0, 255); end
                4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            run_op(s, r, a, b, T'($urandom), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
